alu_issue_ctrl: RTL and testbench
=================================

ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 8, register and ALU datapath width.
REQ-002 SHALL have parameter NREG, default 8, number of general registers (3-bit index).
REQ-003 SHALL have clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have instr_valid  input  1  instruction offered.
REQ-006 SHALL have instr  input  9  instruction: [8:5] opcode, [4:2] rd (also rs1), [1:0] rs2 index (r0-r3) and constant.
REQ-007 SHALL have instr_ready  output  1  block can accept an instruction this cycle.
REQ-008 SHALL have opcode  output  4  opcode driven to the ALU.
REQ-009 SHALL have alu_rs1, alu_rs2  output  DATA_W each  ALU operands.
REQ-010 SHALL have constant  output  2  ALU immediate.
REQ-011 SHALL have aluOut  input  DATA_W  ALU result, combinational from the above.
REQ-012 SHALL have wb_valid  output  1  one-cycle writeback strobe.
REQ-013 SHALL have wb_rd  output  3  and wb_data  output  DATA_W  writeback target and value.
REQ-014 SHALL have illegal  output  1  one-cycle pulse for an undefined opcode.
REQ-015 SHALL have retire_cnt  output  16  count of legal retired instructions.
REQ-016 SHALL have dbg_we  input  1, dbg_addr  input  3, dbg_wdata  input  DATA_W, dbg_rdata  output  DATA_W  register-file debug port.

Function
REQ-017 SHALL implement FSM IDLE -> EXEC -> WB -> IDLE; exactly 3 cycles per instruction, no pipelining.
REQ-018 SHALL assert instr_ready only in IDLE; instruction accepted on edge where instr_valid & instr_ready; instr latched; state -> EXEC.
REQ-019 IDLE with instr_valid low SHALL remain IDLE; instr ignored outside IDLE.
REQ-020 In EXEC SHALL drive opcode=instr[8:5], alu_rs1=rf[instr[4:2]], alu_rs2=rf[{0,instr[1:0]}], constant=instr[1:0], and capture aluOut into a result register at the EXEC->WB edge.
REQ-021 Outside EXEC, opcode, alu_rs1, alu_rs2, constant SHALL be 0.
REQ-022 Legal opcodes SHALL be 4'b0000-4'b1010; in WB a legal instruction SHALL write result to rf[rd], assert wb_valid=1, wb_rd=rd, wb_data=result, and increment retire_cnt by 1 (wraps 0xFFFF->0x0000).
REQ-023 Opcodes 4'b1011-4'b1111 SHALL still traverse EXEC and WB but in WB assert illegal=1, wb_valid=0, no register write, retire_cnt unchanged.
REQ-024 wb_valid, illegal SHALL be high only in WB; wb_rd/wb_data SHALL be 0 when wb_valid=0.
REQ-025 dbg_rdata SHALL be combinational rf[dbg_addr]; during WB it SHALL return the pre-write value of the target register.
REQ-026 dbg_we SHALL write rf[dbg_addr]=dbg_wdata only in IDLE; ignored in EXEC/WB.
REQ-027 dbg_we in IDLE concurrent with instruction acceptance SHALL perform the write; the accepted instruction reads the new value in EXEC.
REQ-028 rd may equal rs1 or rs2; operands SHALL be the pre-instruction values.

Reset
REQ-029 reset SHALL force IDLE, all rf entries 0, result 0, retire_cnt 0, wb_valid 0, illegal 0; instr_ready=1 first cycle after release.
REQ-030 reset during EXEC or WB SHALL abort: no register write, no wb_valid, no retire increment; reset takes priority over dbg_we.

Verification
REQ-031 Reset: after reset -> instr_ready=1, wb_valid=0, illegal=0, retire_cnt=0, dbg_rdata=0 for all 8 addresses.
REQ-032 Add: dbg write r2=0x05, r1=0x03; issue instr=9'b0000_010_01 -> EXEC: opcode=0, alu_rs1=0x05, alu_rs2=0x03; WB: wb_valid=1, wb_rd=2, wb_data=0x08; r2=0x08; retire_cnt=1.
REQ-033 Addi: r4=0x10; instr=9'b0001_100_11 with real ALU -> EXEC constant=2'b11; WB wb_data=0x0F, r4=0x0F.
REQ-034 Illegal: instr=9'b1100_011_00 -> illegal=1 in WB for one cycle, wb_valid=0, r3 unchanged, retire_cnt unchanged.
REQ-035 Back-to-back: instr_valid held high with two instructions -> acceptances exactly 3 cycles apart, instr_ready low in EXEC/WB, second instruction sees first's writeback.
REQ-036 Reset mid-op: assert reset in EXEC of an add to r2 -> no wb_valid, r2=0, retire_cnt=0, IDLE next cycle.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: unpipelined IDLE/EXEC/WB issue controller with register file, external ALU hookup and debug port
module alu_issue_ctrl #(
  parameter int DATA_W = 8,
  parameter int NREG   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              instr_valid,
  input  logic [8:0]        instr,
  output logic              instr_ready,
  output logic [3:0]        opcode,
  output logic [DATA_W-1:0] alu_rs1,
  output logic [DATA_W-1:0] alu_rs2,
  output logic [1:0]        constant,
  input  logic [DATA_W-1:0] aluOut,
  output logic              wb_valid,
  output logic [2:0]        wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              illegal,
  output logic [15:0]       retire_cnt,
  input  logic              dbg_we,
  input  logic [2:0]        dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic [DATA_W-1:0] dbg_rdata
);
  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;
  state_t            r_state, w_next;
  logic [8:0]        r_instr;
  logic [DATA_W-1:0] r_result;
  logic [DATA_W-1:0] r_rf [NREG];
  logic [15:0]       r_retire;
  logic              w_idle, w_exec, w_wb, w_legal, w_accept;
  // state register
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else r_state <= w_next;
  end
  // next state and ALU/writeback outputs; operands are only driven during EXEC
  always_comb begin
    w_idle      = r_state == IDLE;
    w_exec      = r_state == EXEC;
    w_wb        = r_state == WB;
    w_accept    = w_idle && instr_valid;
    w_legal     = r_instr[8:5] <= 4'd10;
    w_next      = w_idle ? (instr_valid ? EXEC : IDLE) : (w_exec ? WB : IDLE);
    instr_ready = w_idle;
    opcode      = w_exec ? r_instr[8:5] : '0;
    alu_rs1     = w_exec ? r_rf[r_instr[4:2]] : '0;
    alu_rs2     = w_exec ? r_rf[{1'b0, r_instr[1:0]}] : '0;
    constant    = w_exec ? r_instr[1:0] : '0;
    wb_valid    = w_wb && w_legal;
    illegal     = w_wb && !w_legal;
    wb_rd       = wb_valid ? r_instr[4:2] : '0;
    wb_data     = wb_valid ? r_result : '0;
    retire_cnt  = r_retire;
    dbg_rdata   = r_rf[dbg_addr];
  end
  // instruction latch, ALU result capture, register file writes and retire count
  always_ff @(posedge clk) begin
    if (reset) begin
      r_instr  <= '0;
      r_result <= '0;
      r_retire <= '0;
      for (int k = 0; k < NREG; k++) r_rf[k] <= '0;
    end else begin
      if (w_accept) r_instr <= instr;
      if (w_idle && dbg_we) r_rf[dbg_addr] <= dbg_wdata;
      if (w_exec) r_result <= aluOut;
      if (wb_valid) begin
        r_rf[r_instr[4:2]] <= r_result;
        r_retire <= r_retire + 16'd1;
      end
    end
  end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed self-checking bench for alu_issue_ctrl with a small behavioural ALU
module tb_alu_issue_ctrl;
  logic       clk = 0, reset = 1, instr_valid = 0, dbg_we = 0;
  logic [8:0] instr = '0;
  logic       instr_ready, wb_valid, illegal;
  logic [3:0] opcode;
  logic [7:0] alu_rs1, alu_rs2, aluOut, wb_data, dbg_wdata = '0, dbg_rdata;
  logic [1:0] constant;
  logic [2:0] wb_rd, dbg_addr = '0;
  logic [15:0] retire_cnt;
  int vecs = 0, errs = 0;

  alu_issue_ctrl #(.DATA_W(8), .NREG(8)) dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .opcode(opcode), .alu_rs1(alu_rs1), .alu_rs2(alu_rs2),
    .constant(constant), .aluOut(aluOut), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .wb_data(wb_data), .illegal(illegal), .retire_cnt(retire_cnt), .dbg_we(dbg_we),
    .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_rdata(dbg_rdata)
  );

  always #5 clk = ~clk;

  // external ALU: add, add sign-extended immediate, sub, and, or, otherwise xor
  always_comb
    aluOut = opcode == 4'd0 ? alu_rs1 + alu_rs2 :
             opcode == 4'd1 ? alu_rs1 + {{6{constant[1]}}, constant} :
             opcode == 4'd2 ? alu_rs1 - alu_rs2 :
             opcode == 4'd3 ? alu_rs1 & alu_rs2 :
             opcode == 4'd4 ? alu_rs1 | alu_rs2 : alu_rs1 ^ alu_rs2;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic dbg_write(input logic [2:0] a, input logic [7:0] d);
    dbg_we = 1; dbg_addr = a; dbg_wdata = d;
    tick();
    dbg_we = 0;
  endtask

  task automatic test_reset();
    reset = 1;
    tick(); tick();
    reset = 0;
    #1;
    vecs++; if (instr_ready !== 1'b1) begin errs++; $display("FAIL reset_ready got=%0h exp=1", instr_ready); end
    vecs++; if (wb_valid !== 1'b0) begin errs++; $display("FAIL reset_wb_valid got=%0h exp=0", wb_valid); end
    vecs++; if (illegal !== 1'b0) begin errs++; $display("FAIL reset_illegal got=%0h exp=0", illegal); end
    vecs++; if (retire_cnt !== 16'd0) begin errs++; $display("FAIL reset_retire got=%0h exp=0", retire_cnt); end
    for (int i = 0; i < 8; i++) begin
      dbg_addr = 3'(i);
      #1;
      vecs++; if (dbg_rdata !== 8'h00) begin errs++; $display("FAIL reset_rf%0d got=%0h exp=0", i, dbg_rdata); end
    end
    tick();
  endtask

  task automatic test_add();
    dbg_write(3'd2, 8'h05);
    dbg_write(3'd1, 8'h03);
    instr = 9'b0000_010_01; instr_valid = 1;
    tick();
    instr_valid = 0; instr = 9'b1111_111_11;
    vecs++; if (instr_ready !== 1'b0) begin errs++; $display("FAIL add_exec_ready got=%0h exp=0", instr_ready); end
    vecs++; if (opcode !== 4'd0) begin errs++; $display("FAIL add_opcode got=%0h exp=0", opcode); end
    vecs++; if (alu_rs1 !== 8'h05) begin errs++; $display("FAIL add_rs1 got=%0h exp=05", alu_rs1); end
    vecs++; if (alu_rs2 !== 8'h03) begin errs++; $display("FAIL add_rs2 got=%0h exp=03", alu_rs2); end
    tick();
    dbg_addr = 3'd2;
    #1;
    vecs++; if (wb_valid !== 1'b1) begin errs++; $display("FAIL add_wb_valid got=%0h exp=1", wb_valid); end
    vecs++; if (wb_rd !== 3'd2) begin errs++; $display("FAIL add_wb_rd got=%0h exp=2", wb_rd); end
    vecs++; if (wb_data !== 8'h08) begin errs++; $display("FAIL add_wb_data got=%0h exp=08", wb_data); end
    vecs++; if (dbg_rdata !== 8'h05) begin errs++; $display("FAIL add_prewrite got=%0h exp=05", dbg_rdata); end
    vecs++; if (opcode !== 4'd0 || alu_rs1 !== 8'h00) begin errs++; $display("FAIL add_wb_operands got=%0h/%0h exp=0/0", opcode, alu_rs1); end
    tick();
    vecs++; if (dbg_rdata !== 8'h08) begin errs++; $display("FAIL add_r2 got=%0h exp=08", dbg_rdata); end
    vecs++; if (retire_cnt !== 16'd1) begin errs++; $display("FAIL add_retire got=%0h exp=1", retire_cnt); end
    vecs++; if (wb_valid !== 1'b0 || instr_ready !== 1'b1) begin errs++; $display("FAIL add_idle got=%0h/%0h exp=0/1", wb_valid, instr_ready); end
  endtask

  task automatic test_addi();
    dbg_we = 1; dbg_addr = 3'd4; dbg_wdata = 8'h10;
    instr = 9'b0001_100_11; instr_valid = 1;
    tick();
    dbg_we = 0; instr_valid = 0;
    vecs++; if (constant !== 2'b11) begin errs++; $display("FAIL addi_constant got=%0h exp=3", constant); end
    vecs++; if (opcode !== 4'd1) begin errs++; $display("FAIL addi_opcode got=%0h exp=1", opcode); end
    vecs++; if (alu_rs1 !== 8'h10) begin errs++; $display("FAIL addi_rs1_newval got=%0h exp=10", alu_rs1); end
    tick();
    vecs++; if (wb_data !== 8'h0F || wb_rd !== 3'd4) begin errs++; $display("FAIL addi_wb got=%0h@%0h exp=0f@4", wb_data, wb_rd); end
    tick();
    dbg_addr = 3'd4; #1;
    vecs++; if (dbg_rdata !== 8'h0F) begin errs++; $display("FAIL addi_r4 got=%0h exp=0f", dbg_rdata); end
    vecs++; if (retire_cnt !== 16'd2) begin errs++; $display("FAIL addi_retire got=%0h exp=2", retire_cnt); end
  endtask

  task automatic test_illegal();
    dbg_write(3'd3, 8'h22);
    instr = 9'b1100_011_00; instr_valid = 1;
    tick();
    instr_valid = 0;
    dbg_we = 1; dbg_addr = 3'd6; dbg_wdata = 8'h77;
    tick();
    dbg_we = 0;
    vecs++; if (illegal !== 1'b1) begin errs++; $display("FAIL ill_pulse got=%0h exp=1", illegal); end
    vecs++; if (wb_valid !== 1'b0 || wb_rd !== 3'd0 || wb_data !== 8'h00) begin errs++; $display("FAIL ill_wb got=%0h/%0h/%0h exp=0/0/0", wb_valid, wb_rd, wb_data); end
    tick();
    dbg_addr = 3'd3; #1;
    vecs++; if (illegal !== 1'b0) begin errs++; $display("FAIL ill_one_cycle got=%0h exp=0", illegal); end
    vecs++; if (dbg_rdata !== 8'h22) begin errs++; $display("FAIL ill_r3 got=%0h exp=22", dbg_rdata); end
    vecs++; if (retire_cnt !== 16'd2) begin errs++; $display("FAIL ill_retire got=%0h exp=2", retire_cnt); end
    dbg_addr = 3'd6; #1;
    vecs++; if (dbg_rdata !== 8'h00) begin errs++; $display("FAIL dbg_busy_write got=%0h exp=0", dbg_rdata); end
  endtask

  task automatic test_opcode_boundary();
    instr = 9'b1010_101_01; instr_valid = 1;
    tick();
    instr_valid = 0;
    tick();
    vecs++; if (wb_valid !== 1'b1 || illegal !== 1'b0 || wb_data !== 8'h03) begin errs++; $display("FAIL op10_legal got=%0h/%0h/%0h exp=1/0/03", wb_valid, illegal, wb_data); end
    tick();
    instr = 9'b1011_101_01; instr_valid = 1;
    tick();
    instr_valid = 0;
    tick();
    vecs++; if (wb_valid !== 1'b0 || illegal !== 1'b1) begin errs++; $display("FAIL op11_illegal got=%0h/%0h exp=0/1", wb_valid, illegal); end
    tick();
    vecs++; if (retire_cnt !== 16'd3) begin errs++; $display("FAIL boundary_retire got=%0h exp=3", retire_cnt); end
  endtask

  task automatic test_back_to_back();
    instr = 9'b0000_010_01; instr_valid = 1;
    #1;
    vecs++; if (instr_ready !== 1'b1) begin errs++; $display("FAIL b2b_ready0 got=%0h exp=1", instr_ready); end
    tick();
    instr = 9'b0000_001_10;
    vecs++; if (instr_ready !== 1'b0 || alu_rs1 !== 8'h08) begin errs++; $display("FAIL b2b_exec1 got=%0h/%0h exp=0/08", instr_ready, alu_rs1); end
    tick();
    vecs++; if (instr_ready !== 1'b0 || wb_data !== 8'h0B) begin errs++; $display("FAIL b2b_wb1 got=%0h/%0h exp=0/0b", instr_ready, wb_data); end
    instr = 9'b0000_001_10;
    tick();
    vecs++; if (instr_ready !== 1'b1) begin errs++; $display("FAIL b2b_accept2 got=%0h exp=1", instr_ready); end
    tick();
    instr_valid = 0;
    vecs++; if (opcode !== 4'd0 || alu_rs1 !== 8'h03 || alu_rs2 !== 8'h0B) begin errs++; $display("FAIL b2b_exec2 got=%0h/%0h/%0h exp=0/03/0b", opcode, alu_rs1, alu_rs2); end
    tick();
    vecs++; if (wb_valid !== 1'b1 || wb_rd !== 3'd1 || wb_data !== 8'h0E) begin errs++; $display("FAIL b2b_wb2 got=%0h/%0h/%0h exp=1/1/0e", wb_valid, wb_rd, wb_data); end
    tick();
    vecs++; if (retire_cnt !== 16'd5) begin errs++; $display("FAIL b2b_retire got=%0h exp=5", retire_cnt); end
  endtask

  task automatic test_reset_mid();
    dbg_write(3'd2, 8'h05);
    instr = 9'b0000_010_01; instr_valid = 1;
    tick();
    instr_valid = 0;
    vecs++; if (opcode !== 4'd0 || alu_rs1 !== 8'h05) begin errs++; $display("FAIL mid_exec got=%0h/%0h exp=0/05", opcode, alu_rs1); end
    reset = 1; dbg_we = 1; dbg_addr = 3'd5; dbg_wdata = 8'h99;
    tick();
    reset = 0; dbg_we = 0;
    vecs++; if (wb_valid !== 1'b0 || instr_ready !== 1'b1) begin errs++; $display("FAIL mid_abort got=%0h/%0h exp=0/1", wb_valid, instr_ready); end
    tick();
    vecs++; if (wb_valid !== 1'b0 || retire_cnt !== 16'd0) begin errs++; $display("FAIL mid_no_wb got=%0h/%0h exp=0/0", wb_valid, retire_cnt); end
    dbg_addr = 3'd2; #1;
    vecs++; if (dbg_rdata !== 8'h00) begin errs++; $display("FAIL mid_r2 got=%0h exp=0", dbg_rdata); end
    dbg_addr = 3'd5; #1;
    vecs++; if (dbg_rdata !== 8'h00) begin errs++; $display("FAIL mid_dbg_prio got=%0h exp=0", dbg_rdata); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_addi();
    test_illegal();
    test_opcode_boundary();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
